// File: rtl/instr_fetch_queue.sv
// PC generator and prefetch queue feeding decode: presents fetch_pc to the combinational
// instruction memory and buffers returned words with their PCs in a circular queue.
module instr_fetch_queue #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [31:0]           imem_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [31:0]           out_instr,
   output logic [ADDR_WIDTH-1:0] fetch_pc
);

   localparam int            PW   = $clog2(DEPTH);
   localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW:0]           count_q, count_d;
   logic [ADDR_WIDTH-1:0] pc_mem_q    [DEPTH];
   logic [31:0]           instr_mem_q [DEPTH];
   logic                  push, pop;
   logic                  unused_redir_lsb;

   assign unused_redir_lsb = ^redirect_pc[1:0];

   assign out_valid = (count_q != '0);
   assign out_pc    = pc_mem_q[rd_ptr_q];
   assign out_instr = instr_mem_q[rd_ptr_q];
   assign fetch_pc  = fetch_pc_q;
   assign imem_addr = fetch_pc_q;

   // A full queue still accepts a word when the head leaves in the same cycle.
   assign pop  = out_valid & out_ready;
   assign push = ~redirect_valid & ((count_q < FULL) | pop);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (redirect_valid) begin
         // Same-cycle pop is simply lost with the rest of the queue contents.
         fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            wr_ptr_d   = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Entries are cleared so the head reads as zero straight out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
         instr_mem_q[wr_ptr_q] <= imem_data;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vector table, hand-written reset/wrap sequences,
// and a randomized run against a queue-based reference model.
module tb_instr_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] fetch_pc;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_fn(input logic [31:0] a);
      case (a)
         32'h0:   return 32'hf0f0a5a5;
         32'h4:   return 32'h0f0f5a5a;
         32'h8:   return 32'hff00ff00;
         32'hC:   return 32'h00ff00ff;
         default: return {a[15:0], ~a[15:0]};
      endcase
   endfunction

   assign imem_data = imem_fn(imem_addr);

   instr_fetch_queue #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_instr(out_instr), .fetch_pc(fetch_pc)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " out_valid"}, {31'b0, out_valid}, 32'h0);
      chk({tag, " out_pc"},    out_pc,    32'h0);
      chk({tag, " out_instr"}, out_instr, 32'h0);
      chk({tag, " fetch_pc"},  fetch_pc,  32'h0);
      chk({tag, " imem_addr"}, imem_addr, 32'h0);
   endtask

   typedef struct packed {
      logic        rst;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] einstr;
      logic [31:0] efetch;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic rdy, input logic rv,
                               input logic [31:0] rpc, input logic ev, input logic [31:0] epc,
                               input logic [31:0] einstr, input logic [31:0] efetch);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
      v.ev = ev; v.epc = epc; v.einstr = einstr; v.efetch = efetch;
      return v;
   endfunction

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   vec_t tbl[$];
   ent_t mq[$];
   logic [31:0] mfetch;

   initial begin
      reset = 1'b1;
      out_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      #2;
      chk_reset_state("power-on reset");

      // Sequence 1: streaming with ready high.
      tbl.push_back(mk(1, 1, 0, 0, 1, 32'h0, 32'hf0f0a5a5, 32'h4));
      tbl.push_back(mk(0, 1, 0, 0, 1, 32'h4, 32'h0f0f5a5a, 32'h8));
      tbl.push_back(mk(0, 1, 0, 0, 1, 32'h8, 32'hff00ff00, 32'hC));
      tbl.push_back(mk(0, 1, 0, 0, 1, 32'hC, 32'h00ff00ff, 32'h10));
      // Sequence 2/3: stall fills the queue, then drain while fetching.
      tbl.push_back(mk(1, 0, 0, 0, 1, 32'h0, 32'hf0f0a5a5, 32'h4));
      tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'hf0f0a5a5, 32'h8));
      tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'hf0f0a5a5, 32'hC));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'hf0f0a5a5, 32'h10));
      tbl.push_back(mk(0, 1, 0, 0, 1, 32'h4, 32'h0f0f5a5a, 32'h14));
      tbl.push_back(mk(0, 1, 0, 0, 1, 32'h8, 32'hff00ff00, 32'h18));
      tbl.push_back(mk(0, 1, 0, 0, 1, 32'hC, 32'h00ff00ff, 32'h1C));
      tbl.push_back(mk(0, 1, 0, 0, 1, 32'h10, imem_fn(32'h10), 32'h20));
      // Sequence 4: redirect with 3 entries queued.
      tbl.push_back(mk(1, 0, 0, 0, 1, 32'h0, 32'hf0f0a5a5, 32'h4));
      tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'hf0f0a5a5, 32'h8));
      tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'hf0f0a5a5, 32'hC));
      tbl.push_back(mk(0, 0, 1, 32'h8, 0, 0, 0, 32'h8));
      tbl.push_back(mk(0, 1, 0, 0, 1, 32'h8, 32'hff00ff00, 32'hC));
      tbl.push_back(mk(0, 1, 0, 0, 1, 32'hC, 32'h00ff00ff, 32'h10));
      // Sequence 5: misaligned redirect, wrap at the top of the address space.
      tbl.push_back(mk(0, 1, 1, 32'h6, 0, 0, 0, 32'h4));
      tbl.push_back(mk(0, 1, 0, 0, 1, 32'h4, 32'h0f0f5a5a, 32'h8));
      tbl.push_back(mk(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC));
      tbl.push_back(mk(0, 1, 0, 0, 1, 32'hFFFF_FFFC, imem_fn(32'hFFFF_FFFC), 32'h0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 32'h0, 32'hf0f0a5a5, 32'h4));
      // Back-to-back redirects: the last one wins.
      tbl.push_back(mk(0, 1, 1, 32'h100, 0, 0, 0, 32'h100));
      tbl.push_back(mk(0, 1, 1, 32'hC, 0, 0, 0, 32'hC));
      tbl.push_back(mk(0, 1, 0, 0, 1, 32'hC, 32'h00ff00ff, 32'h10));

      @(posedge clk); #1;
      foreach (tbl[k]) begin
         if (tbl[k].rst) begin
            reset = 1'b1;
            #1;
            chk("table reset", {31'b0, out_valid}, 32'h0);
            reset = 1'b0;
            #1;
         end
         out_ready = tbl[k].rdy;
         redirect_valid = tbl[k].rv;
         redirect_pc = tbl[k].rpc;
         @(posedge clk); #1;
         chk($sformatf("vec%0d out_valid", k), {31'b0, out_valid}, {31'b0, tbl[k].ev});
         chk($sformatf("vec%0d fetch_pc", k), fetch_pc, tbl[k].efetch);
         chk($sformatf("vec%0d imem_addr", k), imem_addr, tbl[k].efetch);
         if (tbl[k].ev) begin
            chk($sformatf("vec%0d out_pc", k), out_pc, tbl[k].epc);
            chk($sformatf("vec%0d out_instr", k), out_instr, tbl[k].einstr);
         end
      end

      // Asynchronous reset mid-stream with a partially filled queue, between edges.
      redirect_valid = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk_reset_state("mid-stream reset");
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a;
         a = 32'(i * 4);
         @(posedge clk); #1;
         chk($sformatf("post-reset%0d out_valid", i), {31'b0, out_valid}, 32'h1);
         chk($sformatf("post-reset%0d out_pc", i), out_pc, a);
         chk($sformatf("post-reset%0d out_instr", i), out_instr, imem_fn(a));
      end

      // Randomized run against the queue model.
      reset = 1'b1;
      #1;
      reset = 1'b0;
      mq.delete();
      mfetch = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         logic pop, push;
         out_ready = ($urandom_range(3) != 0);
         redirect_valid = ($urandom_range(15) == 0);
         redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                : 32'($urandom_range(255));
         pop = (mq.size() != 0) && out_ready;
         if (redirect_valid) begin
            mq.delete();
            mfetch = redirect_pc & 32'hFFFF_FFFC;
         end else begin
            push = (mq.size() < DEPTH) || pop;
            if (pop) void'(mq.pop_front());
            if (push) begin
               mq.push_back('{pc: mfetch, instr: imem_fn(mfetch)});
               mfetch = mfetch + 32'd4;
            end
         end
         @(posedge clk); #1;
         chk("rand out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
         chk("rand fetch_pc", fetch_pc, mfetch);
         if (mq.size() != 0) begin
            chk("rand out_pc", out_pc, mq[0].pc);
            chk("rand out_instr", out_instr, mq[0].instr);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
